instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ERR_ZERO_IMM, default 0; when 1, any word flagged out_err carries an all-zero immediate field.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: request present.
REQ-005 SHALL have port in_ready, output, 1 bit: request accepted when in_valid and in_ready are both high.
REQ-006 SHALL have port in_fmt, input, 3 bits: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 LI pseudo, 7 reserved.
REQ-007 SHALL have ports in_opcode (7), in_funct3 (3), in_funct7 (7), in_rd (5), in_rs1 (5) and in_rs2 (5), all inputs: instruction fields.
REQ-008 SHALL have port in_imm, input, 32 bits: full signed byte-offset or value immediate.
REQ-009 SHALL have port out_valid, output, 1 bit: output word present.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the word when out_valid and out_ready are both high.
REQ-011 SHALL have port out_instr, output, 32 bits: encoded RV32I word.
REQ-012 SHALL have port out_err, output, 1 bit: immediate not representable, or reserved format.

Function
REQ-013 SHALL register outputs: a request accepted in cycle N appears on out_instr and out_valid in cycle N+1.
REQ-014 SHALL drive in_ready = (!out_valid || out_ready) && state==IDLE.
REQ-015 SHALL hold out_instr, out_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-016 SHALL pack the R format from funct7, rs2, rs1, funct3, rd and opcode, ignoring in_imm; out_err=0.
REQ-017 SHALL pack the I and S formats from imm[11:0]; out_err=1 unless imm[31:11] is all equal.
REQ-018 SHALL pack the B format from imm[12:1]; out_err=1 if imm[0]=1 or imm[31:12] is not all equal.
REQ-019 SHALL pack the J format from imm[20:1]; out_err=1 if imm[0]=1 or imm[31:20] is not all equal.
REQ-020 SHALL pack the U format from imm[31:12]; out_err=1 if imm[11:0]!=0.
REQ-021 SHALL encode an errored word from the truncated immediate bits, or a zero immediate if ERR_ZERO_IMM=1.
REQ-022 SHALL emit out_instr=0 with out_err=1 for fmt 7.
REQ-023 SHALL use an FSM with states IDLE and SECOND; only LI leaves IDLE.
REQ-024 SHALL handle LI with a value that fits 12-bit signed as one word, ADDI rd,x0,imm[11:0], and stay in IDLE.
REQ-025 SHALL handle other LI values by emitting LUI rd with upper=(imm+0x800)[31:12].
REQ-026 SHALL, for an LI whose imm[11:0]!=0, go to SECOND after emitting the LUI word.
REQ-027 SHALL, for an LI whose imm[11:0]=0, emit the LUI word only and stay in IDLE.
REQ-028 SHALL, in SECOND, emit ADDI rd,rd,imm[11:0] from a latched copy of the request when the output slot frees, then return to IDLE.
REQ-029 SHALL hold in_ready=0 throughout SECOND.
REQ-030 SHALL ignore the in_opcode, in_funct3 and in_funct7 inputs for LI.
REQ-031 SHALL compute imm+0x800 modulo 2^32, so 0x7FFFF800..0x7FFFFFFF wrap correctly.

Reset
REQ-032 SHALL, on reset assertion, immediately force state=IDLE, out_valid=0, out_instr=0 and out_err=0, and clear the latched request.
REQ-033 SHALL drop a pending LI second word when reset asserts mid-sequence; no word is emitted after reset releases.
REQ-034 SHALL drive in_ready=1 in the first cycle after reset release.

Structure
REQ-035 SHALL place the format codes, RV32I opcode constants (OP_IMM 0010011, LUI 0110111, and the rest) and FSM state encodings in package riscv_enc_pkg.
REQ-036 SHALL use one combinational sub-module, imm_pack: inputs fmt, fields and imm; outputs word and err. The FSM and registers live in instr_encoder.

Verification
REQ-037 Bench SHALL cover: I fmt, opcode 0x13, rd=1, rs1=0, imm=-1 -> 0xFFF00093, err=0, one cycle latency.
REQ-038 Bench SHALL cover: LI rd=5, imm=0x12345678 -> 0x123452B7 then 0x67828293; in_ready=0 between the two words.
REQ-039 Bench SHALL cover: LI rd=5, imm=0x00000800 -> 0x000012B7 then 0x80028293 (rounding case).
REQ-040 Bench SHALL cover: B fmt, opcode 0x63, rs1=1, rs2=2, imm=8 -> 0x00208463, err=0; the same request with imm=3 -> err=1.
REQ-041 Bench SHALL cover: out_ready=0 for 5 cycles with a word pending -> word unchanged, in_ready=0, no request lost.
REQ-042 Bench SHALL cover: reset asserted in SECOND -> out_valid=0 immediately, no ADDI word after release.

Source files
------------

// File: rtl/riscv_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_enc_pkg
// Brief    : Format codes, RV32I opcodes and FSM state encodings for the encoder
// Revision : 1.0 - initial release
// ============================================================================
package riscv_enc_pkg;

    localparam logic [2:0] c_fmt_r   = 3'd0;
    localparam logic [2:0] c_fmt_i   = 3'd1;
    localparam logic [2:0] c_fmt_s   = 3'd2;
    localparam logic [2:0] c_fmt_b   = 3'd3;
    localparam logic [2:0] c_fmt_u   = 3'd4;
    localparam logic [2:0] c_fmt_j   = 3'd5;
    localparam logic [2:0] c_fmt_li  = 3'd6;
    localparam logic [2:0] c_fmt_rsv = 3'd7;

    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_op_imm = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_second = 1'b1;

    // True when the value is reachable by sign-extending its low 12 bits.
    function automatic logic fits_simm12(input logic [31:0] imm);
        return (imm[31:11] == '0) || (imm[31:11] == '1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ============================================================================
// Module   : imm_pack
// Brief    : Combinational RV32I word packer with immediate range checking
// Revision : 1.0 - initial release
// ============================================================================
module imm_pack
    import riscv_enc_pkg::*;
#(
    parameter int ERR_ZERO_IMM = 0
) (
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);

    logic [31:0] w_imm;

    always_comb begin
        err = 1'b0;
        case (fmt)
            c_fmt_r:          err = 1'b0;
            c_fmt_i, c_fmt_s: err = !fits_simm12(imm);
            c_fmt_b:          err = imm[0] || !((imm[31:12] == '0) || (imm[31:12] == '1));
            c_fmt_j:          err = imm[0] || !((imm[31:20] == '0) || (imm[31:20] == '1));
            c_fmt_u:          err = (imm[11:0] != 12'd0);
            default:          err = 1'b1;
        endcase
    end

    assign w_imm = ((ERR_ZERO_IMM != 0) && err) ? 32'd0 : imm;

    always_comb begin
        word = 32'd0;
        case (fmt)
            c_fmt_r: word = {funct7, rs2, rs1, funct3, rd, opcode};
            c_fmt_i: word = {w_imm[11:0], rs1, funct3, rd, opcode};
            c_fmt_s: word = {w_imm[11:5], rs2, rs1, funct3, w_imm[4:0], opcode};
            c_fmt_b: word = {w_imm[12], w_imm[10:5], rs2, rs1, funct3,
                             w_imm[4:1], w_imm[11], opcode};
            c_fmt_u: word = {w_imm[31:12], rd, opcode};
            c_fmt_j: word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], rd, opcode};
            default: word = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Registered RV32I encoder with LI pseudo expansion (LUI + ADDI)
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int ERR_ZERO_IMM = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
);

    logic [0:0]  r_state;
    logic [0:0]  w_state_d;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic        r_out_err;
    logic [4:0]  r_lat_rd;
    logic [11:0] r_lat_lo;

    logic        w_out_free;
    logic        w_accept;
    logic        w_is_li;
    logic        w_li_fits;
    logic [19:0] w_li_upper;
    logic        w_load;
    logic        w_latch;

    logic [2:0]  w_p_fmt;
    logic [6:0]  w_p_opcode;
    logic [2:0]  w_p_funct3;
    logic [4:0]  w_p_rd;
    logic [4:0]  w_p_rs1;
    logic [31:0] w_p_imm;
    logic [31:0] w_word;
    logic        w_err;

    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = w_out_free && (r_state == c_st_idle);
    assign w_accept   = in_valid && in_ready;
    assign w_is_li    = (in_fmt == c_fmt_li);
    assign w_li_fits  = fits_simm12(in_imm);
    // Rounds the upper part so the sign-extended ADDI lands on the exact value.
    assign w_li_upper = in_imm[31:12] + {19'd0, in_imm[11]};

    always_comb begin
        w_state_d  = r_state;
        w_load     = 1'b0;
        w_latch    = 1'b0;
        w_p_fmt    = in_fmt;
        w_p_opcode = in_opcode;
        w_p_funct3 = in_funct3;
        w_p_rd     = in_rd;
        w_p_rs1    = in_rs1;
        w_p_imm    = in_imm;
        if (r_state == c_st_second) begin
            w_p_fmt    = c_fmt_i;
            w_p_opcode = c_op_op_imm;
            w_p_funct3 = 3'b000;
            w_p_rd     = r_lat_rd;
            w_p_rs1    = r_lat_rd;
            w_p_imm    = {{20{r_lat_lo[11]}}, r_lat_lo};
            if (w_out_free) begin
                w_load    = 1'b1;
                w_state_d = c_st_idle;
            end
        end else begin
            if (w_is_li) begin
                w_p_funct3 = 3'b000;
                if (w_li_fits) begin
                    w_p_fmt    = c_fmt_i;
                    w_p_opcode = c_op_op_imm;
                    w_p_rs1    = 5'd0;
                end else begin
                    w_p_fmt    = c_fmt_u;
                    w_p_opcode = c_op_lui;
                    w_p_imm    = {w_li_upper, 12'd0};
                end
            end
            if (w_accept) begin
                w_load = 1'b1;
                if (w_is_li && !w_li_fits && (in_imm[11:0] != 12'd0)) begin
                    w_latch   = 1'b1;
                    w_state_d = c_st_second;
                end
            end
        end
    end

    imm_pack #(
        .ERR_ZERO_IMM (ERR_ZERO_IMM)
    ) u_imm_pack (
        .fmt    (w_p_fmt),
        .opcode (w_p_opcode),
        .funct3 (w_p_funct3),
        .funct7 (in_funct7),
        .rd     (w_p_rd),
        .rs1    (w_p_rs1),
        .rs2    (in_rs2),
        .imm    (w_p_imm),
        .word   (w_word),
        .err    (w_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_err   <= 1'b0;
            r_lat_rd    <= 5'd0;
            r_lat_lo    <= 12'd0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_word;
                r_out_err   <= w_err;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_latch) begin
                r_lat_rd <= in_rd;
                r_lat_lo <= in_imm[11:0];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire
